// File: rtl/throw_power_meter.sv
// Throw power meter: synchronizes and debounces the throw button, sweeps a ping-pong
// power level while it is held, and fires a one-cycle trigger with the level on release.
module throw_power_meter #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STEP_DIV        = 40000,
  parameter logic [7:0]  MIN_POWER       = 8'd16,
  parameter logic [7:0]  MAX_POWER       = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       throw_button,
  input  logic       enable,
  output logic       throw_trigger,
  output logic [7:0] throw_power,
  output logic       charging,
  output logic [7:0] power_level
);

  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TickW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(STEP_DIV - 1);
  localparam logic [7:0]       MaxDown  = MAX_POWER - 8'd1;
  localparam logic [7:0]       MinUp    = MIN_POWER + 8'd1;

  typedef enum logic [1:0] {
    StIdle,
    StCharging,
    StFire
  } state_e;

  state_e state_q, state_d;

  // Input path
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic [1:0]     sync_vld_q, sync_vld_d;
  logic           btn_db_q, btn_db_d;
  logic           btn_prev_q, btn_prev_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           armed_q, armed_d;
  logic [DbW-1:0] arm_cnt_q, arm_cnt_d;
  logic           press, release_evt;

  // Charge datapath
  logic [7:0]       level_q, level_d;
  logic             dir_up_q, dir_up_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [7:0]       throw_power_q, throw_power_d;
  logic [7:0]       level_step;
  logic             dir_step;

  always_comb begin
    sync1_d    = throw_button;
    sync2_d    = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
  end

  // Debouncer: accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    btn_db_d   = btn_db_q;
    db_cnt_d   = '0;
    btn_prev_d = btn_db_q;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // A button held through reset must be seen stably released before any press counts.
  always_comb begin
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;
    if (!armed_q) begin
      if (!sync_vld_q[1] || sync2_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == DbLast) begin
        armed_d   = 1'b1;
        arm_cnt_d = '0;
      end else begin
        arm_cnt_d = arm_cnt_q + DbW'(1);
      end
    end
  end

  assign press       = btn_db_q & ~btn_prev_q & armed_q;
  assign release_evt = ~btn_db_q & btn_prev_q;

  // Ping-pong step: bounce off either end instead of overshooting it.
  always_comb begin
    if (dir_up_q) begin
      if (level_q >= MAX_POWER) begin
        level_step = MaxDown;
        dir_step   = 1'b0;
      end else begin
        level_step = level_q + 8'd1;
        dir_step   = 1'b1;
      end
    end else begin
      if (level_q <= MIN_POWER) begin
        level_step = MinUp;
        dir_step   = 1'b1;
      end else begin
        level_step = level_q - 8'd1;
        dir_step   = 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; abort on enable loss takes priority over release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (press && enable) state_d = StCharging;
      end
      StCharging: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (release_evt) begin
          state_d = StFire;
        end
      end
      StFire:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state; a release beats a coincident tick so the pre-step level is kept
  always_comb begin
    level_d       = level_q;
    dir_up_d      = dir_up_q;
    tick_d        = tick_q;
    throw_power_d = throw_power_q;
    unique case (state_q)
      StIdle: begin
        if (press && enable) begin
          level_d  = MIN_POWER;
          dir_up_d = 1'b1;
          tick_d   = '0;
        end
      end
      StCharging: begin
        if (enable && release_evt) begin
          throw_power_d = level_q;
        end else if (enable) begin
          if (tick_q == TickLast) begin
            tick_d   = '0;
            level_d  = level_step;
            dir_up_d = dir_step;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync_vld_q    <= '0;
      btn_db_q      <= 1'b0;
      btn_prev_q    <= 1'b0;
      db_cnt_q      <= '0;
      armed_q       <= 1'b0;
      arm_cnt_q     <= '0;
      level_q       <= '0;
      dir_up_q      <= 1'b1;
      tick_q        <= '0;
      throw_power_q <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync_vld_q    <= sync_vld_d;
      btn_db_q      <= btn_db_d;
      btn_prev_q    <= btn_prev_d;
      db_cnt_q      <= db_cnt_d;
      armed_q       <= armed_d;
      arm_cnt_q     <= arm_cnt_d;
      level_q       <= level_d;
      dir_up_q      <= dir_up_d;
      tick_q        <= tick_d;
      throw_power_q <= throw_power_d;
    end
  end

  // FSM outputs
  always_comb begin
    throw_trigger = (state_q == StFire);
    charging      = (state_q == StCharging);
    power_level   = (state_q == StCharging) ? level_q : 8'd0;
    throw_power   = throw_power_q;
  end

endmodule

// File: tb/tb_throw_power_meter.sv
// Directed bench for throw_power_meter with small parameters so every debounce delay,
// sweep step and capture point is hand-computed.
module tb_throw_power_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       throw_button;
  logic       enable;
  logic       throw_trigger;
  logic [7:0] throw_power;
  logic       charging;
  logic [7:0] power_level;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int base;
  logic prev_trig = 1'b0;

  // Level after 2k cycles of charging (STEP_DIV=2, MIN=2, MAX=8)
  int lv[25] = '{2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2,
                 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2};

  throw_power_meter #(
    .DEBOUNCE_CYCLES(4),
    .STEP_DIV       (2),
    .MIN_POWER      (8'd2),
    .MAX_POWER      (8'd8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .throw_button (throw_button),
    .enable       (enable),
    .throw_trigger(throw_trigger),
    .throw_power  (throw_power),
    .charging     (charging),
    .power_level  (power_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (throw_trigger === 1'b1) begin
      trig_cnt++;
      checks++;
      assert (prev_trig === 1'b0) else begin
        errors++;
        $error("FAIL trig_back_to_back: observed 1, expected 0");
      end
    end
    prev_trig = throw_trigger;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Clean press: debounce plus FSM gives exactly 7 cycles to charging
  task automatic start_charge(input string tag);
    throw_button = 1'b1;
    step(6);
    chk({tag, "_pre"}, charging, 0);
    step(1);
    chk({tag, "_charging"}, charging, 1);
    chk({tag, "_level"}, power_level, 2);
  endtask

  initial begin
    // 1: reset with button held
    rst = 1'b1;
    throw_button = 1'b1;
    enable = 1'b1;
    step(3);
    chk("rst_trigger", throw_trigger, 0);
    chk("rst_power", throw_power, 0);
    chk("rst_charging", charging, 0);
    chk("rst_level", power_level, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("held_no_charge", charging, 0);
    end
    chk("held_no_trig", trig_cnt, 0);
    throw_button = 1'b0;
    step(12);
    start_charge("fresh_press");

    // 2: sweep up to 8, release on the way down at 7 (tick coincides with release)
    base = trig_cnt;
    for (int i = 0; i < 16; i++) begin
      chk("t2_charging", charging, 1);
      chk("t2_level", power_level, lv[i / 2]);
      if (i == 9) throw_button = 1'b0;
      step(1);
    end
    chk("t2_trigger", throw_trigger, 1);
    chk("t2_power", throw_power, 7);
    chk("t2_charging_off", charging, 0);
    chk("t2_level_off", power_level, 0);
    step(1);
    chk("t2_trigger_low", throw_trigger, 0);
    chk("t2_power_held", throw_power, 7);
    chk("t2_one_trigger", trig_cnt - base, 1);
    step(5);

    // 3: full sweep 2..8..2..8..2, release at MIN
    start_charge("t3_press");
    base = trig_cnt;
    for (int i = 0; i < 49; i++) begin
      chk("t3_level", power_level, lv[i / 2]);
      if (i == 42) throw_button = 1'b0;
      step(1);
    end
    chk("t3_trigger", throw_trigger, 1);
    chk("t3_power", throw_power, 2);
    step(1);
    chk("t3_one_trigger", trig_cnt - base, 1);
    step(5);

    // 4: bouncing button never gets through the debouncer
    base = trig_cnt;
    for (int i = 0; i < 10; i++) begin
      throw_button = ~throw_button;
      step(2);
      chk("t4_no_charge", charging, 0);
    end
    step(10);
    chk("t4_no_charge_end", charging, 0);
    chk("t4_no_trigger", trig_cnt - base, 0);
    chk("t4_power_kept", throw_power, 2);

    // 5: enable drops at level 5 -> abort
    start_charge("t5_press");
    base = trig_cnt;
    step(6);
    chk("t5_level5", power_level, 5);
    enable = 1'b0;
    step(1);
    chk("t5_abort_charging", charging, 0);
    chk("t5_abort_level", power_level, 0);
    chk("t5_abort_trigger", throw_trigger, 0);
    chk("t5_abort_power", throw_power, 2);
    throw_button = 1'b0;
    step(12);
    enable = 1'b1;
    step(3);
    chk("t5_no_trigger", trig_cnt - base, 0);
    chk("t5_power_kept", throw_power, 2);

    // 6: press while disabled, enable while held -> nothing; re-press charges
    enable = 1'b0;
    throw_button = 1'b1;
    step(12);
    chk("t6_disabled", charging, 0);
    enable = 1'b1;
    step(12);
    chk("t6_held_enable", charging, 0);
    chk("t6_held_level", power_level, 0);
    throw_button = 1'b0;
    step(12);
    start_charge("t6_repress");
    step(1);
    throw_button = 1'b0;
    step(7);
    chk("t6_trigger", throw_trigger, 1);
    chk("t6_power", throw_power, 5);
    step(3);

    // 7: reset mid-charge clears everything, held button stays ignored
    start_charge("t7_press");
    base = trig_cnt;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t7_charging", charging, 0);
    chk("t7_power", throw_power, 0);
    chk("t7_level", power_level, 0);
    chk("t7_trigger", throw_trigger, 0);
    step(12);
    chk("t7_held_no_charge", charging, 0);
    chk("t7_no_trigger", trig_cnt - base, 0);
    throw_button = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
